// File: rtl/cache_mem_arbiter.sv
// Round-robin arbiter sharing the single cacheline adaptor port between the I-cache and D-cache.
// The grant is registered; address, data and response are steered combinationally to the granted client.
module cache_mem_arbiter #(
  parameter int ADDR_W = 32,
  parameter int LINE_W = 256
) (
  input  logic              clk,
  input  logic              rst,

  input  logic              i_read,
  input  logic              i_write,
  input  logic [ADDR_W-1:0] i_addr,
  input  logic [LINE_W-1:0] i_wdata,
  output logic [LINE_W-1:0] i_rdata,
  output logic              i_resp,

  input  logic              d_read,
  input  logic              d_write,
  input  logic [ADDR_W-1:0] d_addr,
  input  logic [LINE_W-1:0] d_wdata,
  output logic [LINE_W-1:0] d_rdata,
  output logic              d_resp,

  output logic              mem_read,
  output logic              mem_write,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [LINE_W-1:0] mem_wdata,
  input  logic [LINE_W-1:0] mem_rdata,
  input  logic              mem_resp,

  output logic              busy
);

  typedef enum logic [1:0] {
    S_IDLE   = 2'd0,
    S_I_BUSY = 2'd1,
    S_D_BUSY = 2'd2
  } state_t;

  state_t state_reg, state_next;
  logic   last_grant_reg, last_grant_next;   // 0 = I-cache, 1 = D-cache
  logic   pending_i, pending_d;

  assign pending_i = i_read | i_write;
  assign pending_d = d_read | d_write;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_reg      <= S_IDLE;
      last_grant_reg <= 1'b0;
    end else begin
      state_reg      <= state_next;
      last_grant_reg <= last_grant_next;
    end
  end

  always_comb begin
    state_next      = state_reg;
    last_grant_next = last_grant_reg;
    mem_read        = 1'b0;
    mem_write       = 1'b0;
    mem_addr        = '0;
    mem_wdata       = '0;
    i_resp          = 1'b0;
    d_resp          = 1'b0;

    case (state_reg)
      S_IDLE: begin
        // On a tie, the client that was not served last wins.
        if (pending_i && pending_d) begin
          if (last_grant_reg) begin
            state_next      = S_I_BUSY;
            last_grant_next = 1'b0;
          end else begin
            state_next      = S_D_BUSY;
            last_grant_next = 1'b1;
          end
        end else if (pending_d) begin
          state_next      = S_D_BUSY;
          last_grant_next = 1'b1;
        end else if (pending_i) begin
          state_next      = S_I_BUSY;
          last_grant_next = 1'b0;
        end
      end

      S_I_BUSY: begin
        mem_addr  = i_addr;
        mem_wdata = i_wdata;
        mem_write = i_write;
        mem_read  = i_read & ~i_write;
        i_resp    = mem_resp;
        if (mem_resp) state_next = S_IDLE;
      end

      S_D_BUSY: begin
        mem_addr  = d_addr;
        mem_wdata = d_wdata;
        mem_write = d_write;
        mem_read  = d_read & ~d_write;
        d_resp    = mem_resp;
        if (mem_resp) state_next = S_IDLE;
      end

      default: state_next = S_IDLE;
    endcase
  end

  assign busy    = (state_reg != S_IDLE);
  assign i_rdata = mem_rdata;
  assign d_rdata = mem_rdata;

  // A granted client asking for read and write at once is a controller bug; write wins above.
  a_no_read_and_write: assert property (@(posedge clk) disable iff (!rst)
    !(((state_reg == S_I_BUSY) && i_read && i_write) ||
      ((state_reg == S_D_BUSY) && d_read && d_write)));

endmodule
